// File: rtl/grant_port_mux.sv
// Funnels one-hot arbiter grants into a single downstream request channel and
// routes in-order downstream responses back to the originating requester.
module grant_port_mux #(
  parameter int unsigned NUM_REQUESTERS  = 4,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQUESTERS-1:0]        i_grants,
  input  logic [NUM_REQUESTERS*DATA_W-1:0] i_req_data,
  output logic [NUM_REQUESTERS-1:0]        o_req_ack,
  output logic                             o_m_valid,
  output logic [DATA_W-1:0]                o_m_data,
  input  logic                             i_m_ready,
  input  logic                             i_r_valid,
  input  logic [DATA_W-1:0]                i_r_data,
  output logic                             o_r_ready,
  output logic [NUM_REQUESTERS-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]                o_rsp_data,
  output logic                             o_busy,
  output logic                             o_err
);

  localparam int unsigned IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic [NUM_REQUESTERS-1:0] ack_q, ack_d;
  logic                      valid_q, valid_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      r_ready_q, r_ready_d;
  logic [NUM_REQUESTERS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]         rsp_data_q, rsp_data_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;
  logic [IDX_W-1:0]          mem_q [MAX_OUTSTANDING];

  logic                      push_c;
  logic                      pop_c;
  logic [IDX_W-1:0]          grant_idx_c;
  logic [DATA_W-1:0]         grant_data_c;
  logic                      grant_any_c;
  logic                      grant_multi_c;

  // Lowest-index granted requester and its payload
  always_comb begin
    grant_idx_c  = '0;
    grant_data_c = '0;
    for (int i = int'(NUM_REQUESTERS) - 1; i >= 0; i--) begin
      if (i_grants[i]) begin
        grant_idx_c  = IDX_W'(i);
        grant_data_c = i_req_data[i*DATA_W +: DATA_W];
      end
    end
    grant_any_c   = (i_grants != '0);
    grant_multi_c = ((i_grants & (i_grants - NUM_REQUESTERS'(1))) != '0);
  end

  // Next-state: request FSM, ID FIFO bookkeeping and response routing
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    ack_d       = '0;
    valid_d     = valid_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    push_c      = 1'b0;
    pop_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_any_c && (count_q < CNT_W'(MAX_OUTSTANDING))) begin
          state_d = ST_HOLD;
          idx_d   = grant_idx_c;
          data_d  = grant_data_c;
          ack_d   = NUM_REQUESTERS'(1) << grant_idx_c;
          valid_d = 1'b1;
          if (grant_multi_c) err_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (i_m_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          push_c  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // r_ready_q mirrors count_q != 0, so a response with an empty FIFO is refused
    pop_c = i_r_valid & r_ready_q;
    if (i_r_valid && !r_ready_q) err_d = 1'b1;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      rsp_valid_d = NUM_REQUESTERS'(1) << mem_q[rd_ptr_q];
      rsp_data_d  = i_r_data;
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    r_ready_d = (count_d != '0);
    busy_d    = (state_d == ST_HOLD) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      data_q      <= '0;
      ack_q       <= '0;
      valid_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      valid_q     <= valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      r_ready_q   <= r_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // ID storage needs no reset: entries are only read while the count is nonzero
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= idx_q;
  end

  assign o_req_ack   = ack_q;
  assign o_m_valid   = valid_q;
  assign o_m_data    = data_q;
  assign o_r_ready   = r_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = busy_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_grant_port_mux.sv
// Scoreboard bench for grant_port_mux: expected acks, downstream payloads and
// routed responses are queued at stimulus time and checked as the DUT emits them.
module tb_grant_port_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 4;

  typedef struct packed {
    logic [N-1:0]  port;
    logic [DW-1:0] data;
  } rsp_t;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      i_grants;
  logic [N*DW-1:0]   i_req_data;
  logic [N-1:0]      o_req_ack;
  logic              o_m_valid;
  logic [DW-1:0]     o_m_data;
  logic              i_m_ready;
  logic              i_r_valid;
  logic [DW-1:0]     i_r_data;
  logic              o_r_ready;
  logic [N-1:0]      o_rsp_valid;
  logic [DW-1:0]     o_rsp_data;
  logic              o_busy;
  logic              o_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0]  exp_ack [$];
  logic [DW-1:0] exp_m   [$];
  rsp_t          exp_rsp [$];

  grant_port_mux #(
    .NUM_REQUESTERS (N),
    .DATA_W         (DW),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_grants   (i_grants),
    .i_req_data (i_req_data),
    .o_req_ack  (o_req_ack),
    .o_m_valid  (o_m_valid),
    .o_m_data   (o_m_data),
    .i_m_ready  (i_m_ready),
    .i_r_valid  (i_r_valid),
    .i_r_data   (i_r_data),
    .o_r_ready  (o_r_ready),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_data (o_rsp_data),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic default_data();
    for (int k = 0; k < int'(N); k++) i_req_data[k*DW +: DW] = DW'(32'hA5A5_0000 + k);
  endtask

  function automatic logic [DW-1:0] port_data(input int port);
    return i_req_data[port*DW +: DW];
  endfunction

  // One grant cycle then one idle cycle; with i_m_ready high the request is pushed
  task automatic request(input int port, input logic [N-1:0] g, input bit expect_m);
    exp_ack.push_back(N'(1) << port);
    if (expect_m) exp_m.push_back(port_data(port));
    i_grants = g;
    tick();
    i_grants = '0;
    tick();
  endtask

  task automatic respond(input logic [DW-1:0] d, input logic [N-1:0] port_oh);
    int waited = 0;
    while (!o_r_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("r_ready_before_rsp", 64'(o_r_ready), 64'd1);
    exp_rsp.push_back('{port: port_oh, data: d});
    i_r_valid = 1'b1;
    i_r_data  = d;
    tick();
    i_r_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"},       64'(o_req_ack),   64'd0);
    chk({tag, "_m_valid"},   64'(o_m_valid),   64'd0);
    chk({tag, "_m_data"},    64'(o_m_data),    64'd0);
    chk({tag, "_r_ready"},   64'(o_r_ready),   64'd0);
    chk({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
    chk({tag, "_rsp_data"},  64'(o_rsp_data),  64'd0);
    chk({tag, "_busy"},      64'(o_busy),      64'd0);
    chk({tag, "_err"},       64'(o_err),       64'd0);
  endtask

  // Output monitor: every emitted ack, downstream handshake and response must be expected
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_req_ack != '0) begin
        if (exp_ack.size() == 0) chk("unexpected_ack", 64'(o_req_ack), 64'd0);
        else chk("ack", 64'(o_req_ack), 64'(exp_ack.pop_front()));
      end
      if (o_m_valid && i_m_ready) begin
        if (exp_m.size() == 0) chk("unexpected_m_push", 64'(o_m_data), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("m_data", 64'(o_m_data), 64'(exp_m.pop_front()));
      end
      if (o_rsp_valid != '0) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 64'(o_rsp_valid), 64'd0);
        else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rsp_valid", 64'(o_rsp_valid), 64'(e.port));
          chk("rsp_data",  64'(o_rsp_data),  64'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] held;
    rst_n     = 1'b1;
    i_grants  = '0;
    i_m_ready = 1'b0;
    i_r_valid = 1'b0;
    i_r_data  = '0;
    default_data();
    #3 rst_n = 1'b0;
    #1 check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single request to port 2 and its response
    i_m_ready = 1'b1;
    request(2, 4'b0100, 1'b1);
    chk("single_busy", 64'(o_busy), 64'd1);
    respond(32'h0000_1234, 4'b0100);
    tick();
    chk("single_idle_busy", 64'(o_busy), 64'd0);

    // Backpressure: payload stays put, grants ignored, no push until ready
    i_m_ready = 1'b0;
    held = port_data(0);
    exp_ack.push_back(4'b0001);
    exp_m.push_back(held);
    i_grants = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      i_grants = (c % 2 == 0) ? 4'b1111 : 4'b0010;
      i_req_data = ~i_req_data;
      tick();
      chk("bp_m_data", 64'(o_m_data), 64'(held));
      chk("bp_m_valid", 64'(o_m_valid), 64'd1);
      chk("bp_no_push", 64'(o_r_ready), 64'd0);
    end
    i_grants = '0;
    default_data();
    i_m_ready = 1'b1;
    tick();
    chk("bp_pushed", 64'(o_r_ready), 64'd1);
    chk("bp_m_valid_low", 64'(o_m_valid), 64'd0);
    respond(32'h0000_0BB0, 4'b0001);

    // FIFO full: fifth grant waits until one response frees a slot
    for (int p = 0; p < 4; p++) request(p, N'(1) << p, 1'b1);
    i_grants = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("full_no_ack", 64'(o_req_ack), 64'd0);
      chk("full_busy", 64'(o_busy), 64'd1);
      chk("full_m_valid", 64'(o_m_valid), 64'd0);
    end
    exp_ack.push_back(4'b0010);
    exp_m.push_back(port_data(1));
    exp_rsp.push_back('{port: 4'b0001, data: 32'h0000_F000});
    i_r_valid = 1'b1;
    i_r_data  = 32'h0000_F000;
    tick();
    i_r_valid = 1'b0;
    chk("full_ack_not_yet", 64'(o_req_ack), 64'd0);
    tick();
    chk("full_capture_ack", 64'(o_req_ack), 64'b0010);
    i_grants = '0;
    tick();
    respond(32'h0000_F001, 4'b0010);
    respond(32'h0000_F002, 4'b0100);
    respond(32'h0000_F003, 4'b1000);
    respond(32'h0000_F004, 4'b0010);
    chk("full_drained", 64'(o_r_ready), 64'd0);

    // Ordering with an overlapping push and pop
    request(3, 4'b1000, 1'b1);
    request(1, 4'b0010, 1'b1);
    exp_ack.push_back(4'b0001);
    exp_m.push_back(port_data(0));
    i_grants = 4'b0001;
    tick();
    i_grants = '0;
    exp_rsp.push_back('{port: 4'b1000, data: 32'h0000_0303});
    i_r_valid = 1'b1;
    i_r_data  = 32'h0000_0303;
    tick();
    i_r_valid = 1'b0;
    chk("ovl_r_ready", 64'(o_r_ready), 64'd1);
    respond(32'h0000_0101, 4'b0010);
    chk("ovl_one_left", 64'(o_r_ready), 64'd1);
    respond(32'h0000_0000, 4'b0001);
    chk("ovl_count_zero", 64'(o_r_ready), 64'd0);
    chk("ovl_busy", 64'(o_busy), 64'd0);
    chk("no_err_yet", 64'(o_err), 64'd0);

    // Multi-bit grant: port 1 wins and the error sticks
    request(1, 4'b0110, 1'b1);
    chk("multi_err", 64'(o_err), 64'd1);
    tick();
    chk("multi_err_sticky", 64'(o_err), 64'd1);
    apply_reset();
    chk("err_cleared", 64'(o_err), 64'd0);
    chk("reset_dropped_id", 64'(o_r_ready), 64'd0);

    // Response with an empty FIFO is refused and flags an error
    i_r_valid = 1'b1;
    i_r_data  = 32'hDEAD_0001;
    chk("empty_r_ready", 64'(o_r_ready), 64'd0);
    tick();
    i_r_valid = 1'b0;
    chk("empty_err", 64'(o_err), 64'd1);
    tick(); tick(); tick();
    chk("empty_err_sticky", 64'(o_err), 64'd1);
    apply_reset();

    // Reset while holding a request with two IDs outstanding
    request(0, 4'b0001, 1'b1);
    request(1, 4'b0010, 1'b1);
    request(2, 4'b0100, 1'b1);
    respond(32'h0000_C0DE, 4'b0001);
    i_m_ready = 1'b0;
    request(3, 4'b1000, 1'b0);
    chk("hold_m_valid", 64'(o_m_valid), 64'd1);
    chk("hold_rsp_data", 64'(o_rsp_data), 64'h0000_C0DE);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    i_m_ready = 1'b1;
    tick(); tick();
    chk("post_reset_m_valid", 64'(o_m_valid), 64'd0);
    i_r_valid = 1'b1;
    i_r_data  = 32'hDEAD_0002;
    chk("post_reset_r_ready", 64'(o_r_ready), 64'd0);
    tick();
    i_r_valid = 1'b0;
    chk("post_reset_err", 64'(o_err), 64'd1);
    tick(); tick();

    chk("exp_ack_left", 64'(exp_ack.size()), 64'd0);
    chk("exp_m_left",   64'(exp_m.size()),   64'd0);
    chk("exp_rsp_left", 64'(exp_rsp.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/grant_port_mux.md
GRANT_PORT_MUX -- requirements
Module: grant_port_mux

Interface
- REQ-001 SHALL have parameter NUM_REQUESTERS, default 4, number of requester ports; legal range 2..16.
- REQ-002 SHALL have parameter DATA_W, default 32, width of request and response payloads.
- REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, depth of the in-order ID FIFO; legal range 2..16, power of two.
- REQ-004 SHALL have port clk, input, 1, clock; all logic is rising-edge.
- REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
- REQ-006 SHALL have port i_grants, input, NUM_REQUESTERS, one-hot grant vector from the upstream round-robin arbiter.
- REQ-007 SHALL have port i_req_data, input, NUM_REQUESTERS*DATA_W, request payloads; requester k occupies bits [k*DATA_W +: DATA_W].
- REQ-008 SHALL have port o_req_ack, output, NUM_REQUESTERS, one-cycle acceptance pulse per requester.
- REQ-009 SHALL have ports o_m_valid (output, 1), o_m_data (output, DATA_W) and i_m_ready (input, 1), forming the downstream request channel.
- REQ-010 SHALL have ports i_r_valid (input, 1), i_r_data (input, DATA_W) and o_r_ready (output, 1), forming the downstream in-order response channel.
- REQ-011 SHALL have ports o_rsp_valid (output, NUM_REQUESTERS) and o_rsp_data (output, DATA_W), the response returned to the originating requester.
- REQ-012 SHALL have port o_busy, output, 1, high when in HOLD or when the ID FIFO is non-empty.
- REQ-013 SHALL have port o_err, output, 1, sticky error flag.

Function
- REQ-014 SHALL implement a request FSM with two states: IDLE and HOLD.
- REQ-015 In IDLE, with i_grants nonzero and FIFO count < MAX_OUTSTANDING, SHALL capture the lowest-index granted requester k and its payload into registers, then move to HOLD.
- REQ-016 SHALL drive o_req_ack[k]=1 for exactly the one cycle after capture; all other ack bits SHALL stay 0.
- REQ-017 In IDLE, SHALL ignore grants while FIFO count == MAX_OUTSTANDING; no capture and no ack.
- REQ-018 In HOLD, SHALL ignore i_grants completely.
- REQ-019 In HOLD, o_m_valid SHALL be 1 and o_m_data SHALL hold the captured payload stable until i_m_ready=1.
- REQ-020 On the HOLD handshake cycle (o_m_valid & i_m_ready), SHALL push k into the ID FIFO and return to IDLE; the earliest next capture is the following cycle (at most one request per 2 cycles).
- REQ-021 SHALL set o_err when i_grants has more than one bit set in a cycle where a capture occurs; the lowest index still wins.
- REQ-022 SHALL drive o_r_ready equal to (FIFO count != 0).
- REQ-023 On i_r_valid & o_r_ready, SHALL pop the head index h; on the next cycle o_rsp_valid SHALL be one-hot at bit h, with o_rsp_data equal to the accepted i_r_data.
- REQ-024 SHALL drive o_rsp_valid to 0 in all other cycles; o_rsp_data SHALL hold its last value when o_rsp_valid is 0.
- REQ-025 SHALL set o_err when i_r_valid=1 while the FIFO is empty; that response is not accepted.
- REQ-026 On simultaneous push and pop, SHALL perform both; the count stays unchanged and order is preserved.
- REQ-027 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING; the count width SHALL be $clog2(MAX_OUTSTANDING)+1.
- REQ-028 o_err SHALL clear only on reset.

Reset
- REQ-029 On rst_n=0, SHALL immediately set: FSM to IDLE, FIFO empty, o_req_ack=0, o_m_valid=0, o_m_data=0, o_r_ready=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0, o_err=0.
- REQ-030 Reset asserted mid-HOLD or with entries outstanding SHALL discard the pending request and all IDs; no ack or response is emitted afterward.

Verification
- REQ-031 Single request: i_grants=4'b0100, data[2]=0xA5A5_0002, i_m_ready=1. Required: o_req_ack=4'b0100 one cycle after capture, o_m_data=0xA5A5_0002. Then i_r_data=0x1234 is returned, and o_rsp_valid=4'b0100 with o_rsp_data=0x1234 one cycle after acceptance.
- REQ-032 Backpressure: i_m_ready=0 for 5 cycles while in HOLD, grants toggling. Required: o_m_data stable, no additional captures or acks, FIFO push only when ready rises.
- REQ-033 FIFO full: four requests from ports 0,1,2,3 with no responses. Required: a fifth grant gives no ack, o_busy=1. Return one response (to port 0). Required: the fifth grant is captured on the next IDLE cycle.
- REQ-034 Ordering and simultaneous push/pop: requests 3,1,0 issued, with responses returned while a new push occurs. Required: o_rsp_valid sequence 1000, 0010, 0001 in order, count unchanged on overlap cycles.
- REQ-035 Errors: a capture with i_grants=4'b0110 captures port 1 and sets o_err. Separately, i_r_valid with the FIFO empty gives o_r_ready=0 and sets o_err, which stays 1 until rst_n.
- REQ-036 Reset in HOLD with 2 IDs outstanding. Required: all outputs 0 immediately; later responses give o_r_ready=0 and set o_err.
